// File: rtl/remove_cp_pkg.sv
// Shared types and defaults for the receive-side cyclic-prefix removal stage.
package remove_cp_pkg;
    localparam int LCP_DEF   = 16;
    localparam int NFFT_DEF  = 48;
    localparam int SAMPLE_W  = 16;
    localparam int SYM_CNT_W = 16;

    typedef enum logic [1:0] {IDLE, SKIP, PASS} state_t;

    // Index width that stays legal for a depth of 1.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // |a-b| of two signed samples, widened to 17 bits so it never overflows.
    function automatic logic [SAMPLE_W:0] abs_diff(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
        logic [SAMPLE_W:0] d;
        d = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
        return d[SAMPLE_W] ? (~d + 1'b1) : d;
    endfunction
endpackage

// File: rtl/remove_cp_if.sv
// Sample stream in, useful-sample stream plus status out.
interface remove_cp_if;
    import remove_cp_pkg::*;

    logic [SAMPLE_W-1:0]  DAT_I_r, DAT_I_i;
    logic                 ACK_I, SYNC_I;
    logic [SAMPLE_W-1:0]  DAT_O_r, DAT_O_i;
    logic                 STB_O, SOF_O, EOF_O, LOCK_O, SYNC_ERR_O, CP_ERR_O;
    logic [SYM_CNT_W-1:0] SYM_CNT_O;

    modport slave (
        input  DAT_I_r, DAT_I_i, ACK_I, SYNC_I,
        output DAT_O_r, DAT_O_i, STB_O, SOF_O, EOF_O, LOCK_O, SYNC_ERR_O, CP_ERR_O, SYM_CNT_O
    );
    modport master (
        output DAT_I_r, DAT_I_i, ACK_I, SYNC_I,
        input  DAT_O_r, DAT_O_i, STB_O, SOF_O, EOF_O, LOCK_O, SYNC_ERR_O, CP_ERR_O, SYM_CNT_O
    );
endinterface

// File: rtl/remove_cp_check.sv
// Prefix-vs-tail consistency checker: buffers the prefix, compares the symbol tail
// against it within CP_TOL per component and keeps a per-symbol sticky error.
module remove_cp_check
    import remove_cp_pkg::*;
#(
    parameter int LCP    = LCP_DEF,
    parameter int CP_TOL = 0,
    localparam int IW    = idx_w(LCP)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic                rd_en,
    input  logic [IW-1:0]       rd_idx,
    input  logic [SAMPLE_W-1:0] dat_r,
    input  logic [SAMPLE_W-1:0] dat_i,
    output logic                err
);
    logic [SAMPLE_W-1:0] buf_r [LCP];
    logic [SAMPLE_W-1:0] buf_i [LCP];
    logic                flag;
    logic                mism;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_r[wr_idx] <= dat_r;
            buf_i[wr_idx] <= dat_i;
        end
    end

    assign mism = (abs_diff(dat_r, buf_r[rd_idx]) > (SAMPLE_W+1)'(CP_TOL)) ||
                  (abs_diff(dat_i, buf_i[rd_idx]) > (SAMPLE_W+1)'(CP_TOL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        flag <= 1'b0;
        else if (clr)   flag <= 1'b0;
        else if (rd_en) flag <= flag | mism;
    end

    // Includes the sample being compared now so the final tail sample is counted.
    assign err = flag | (rd_en & mism);
endmodule

// File: rtl/remove_cp.sv
// Cyclic-prefix removal: drops LCP prefix samples, forwards NFFT useful samples with
// SOF/EOF. Define REMOVE_CP_CHECK_EN to enable the prefix consistency check.
module remove_cp
    import remove_cp_pkg::*;
#(
    parameter int LCP    = LCP_DEF,
    parameter int NFFT   = NFFT_DEF,
    parameter int CP_TOL = 0
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    remove_cp_if.slave  bus
);
    localparam int CW = $clog2(NFFT + 1);

    if (LCP < 1 || LCP > NFFT || NFFT < 2 || CP_TOL < 0) begin : g_bad_cfg
        $error("remove_cp: illegal LCP/NFFT/CP_TOL combination");
    end

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [SAMPLE_W-1:0]  dat_r, dat_i;
    logic                 stb, sof, eof, sync_err, cp_err;
    logic [SYM_CNT_W-1:0] sym_cnt;

    logic ack, sync, at_boundary, sync_bad, fwd, last, cp_err_now;

    assign ack         = bus.ACK_I;
    assign sync        = bus.SYNC_I;
    assign at_boundary = (state == SKIP) && (cnt == '0);
    // A SYNC in IDLE is first acquisition, not an error.
    assign sync_bad    = ack && sync && (state != IDLE) && !at_boundary;
    assign fwd         = ack && !sync && (state == PASS);
    assign last        = (cnt == CW'(NFFT - 1));

`ifdef REMOVE_CP_CHECK_EN
    localparam int IW = idx_w(LCP);
    logic          chk_clr, chk_wr, chk_rd;
    logic [IW-1:0] chk_wr_idx, chk_rd_idx;

    assign chk_clr    = ack && (sync || at_boundary);
    assign chk_wr     = ack && (sync || (state == SKIP));
    assign chk_wr_idx = sync ? '0 : IW'(cnt);
    assign chk_rd     = fwd && (cnt >= CW'(NFFT - LCP));
    assign chk_rd_idx = IW'(cnt - CW'(NFFT - LCP));

    remove_cp_check #(.LCP(LCP), .CP_TOL(CP_TOL)) u_check (
        .clk    (CLK_I),
        .rst    (RST_I),
        .clr    (chk_clr),
        .wr_en  (chk_wr),
        .wr_idx (chk_wr_idx),
        .rd_en  (chk_rd),
        .rd_idx (chk_rd_idx),
        .dat_r  (bus.DAT_I_r),
        .dat_i  (bus.DAT_I_i),
        .err    (cp_err_now)
    );
`else
    assign cp_err_now = 1'b0;
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= IDLE;
            cnt      <= '0;
            dat_r    <= '0;
            dat_i    <= '0;
            stb      <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            sync_err <= 1'b0;
            cp_err   <= 1'b0;
            sym_cnt  <= '0;
        end else begin
            stb      <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            cp_err   <= 1'b0;
            sync_err <= sync_bad;
            if (ack) begin
                if (sync) begin
                    // Any accepted SYNC restarts the symbol with this sample as prefix 0.
                    state <= (LCP == 1) ? PASS : SKIP;
                    cnt   <= (LCP == 1) ? '0 : CW'(1);
                end else begin
                    case (state)
                        SKIP: begin
                            if (cnt == CW'(LCP - 1)) begin
                                state <= PASS;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        PASS: begin
                            stb   <= 1'b1;
                            dat_r <= bus.DAT_I_r;
                            dat_i <= bus.DAT_I_i;
                            sof   <= (cnt == '0);
                            eof   <= last;
                            if (last) begin
                                cp_err  <= cp_err_now;
                                sym_cnt <= sym_cnt + 1'b1;
                                state   <= SKIP;
                                cnt     <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.DAT_O_r    = dat_r;
    assign bus.DAT_O_i    = dat_i;
    assign bus.STB_O      = stb;
    assign bus.SOF_O      = sof;
    assign bus.EOF_O      = eof;
    assign bus.LOCK_O     = (state != IDLE);
    assign bus.SYNC_ERR_O = sync_err;
    assign bus.CP_ERR_O   = cp_err;
    assign bus.SYM_CNT_O  = sym_cnt;
endmodule

// File: tb/tb_remove_cp.sv
// Directed bench for remove_cp: steady stream, gaps, early SYNC, mid-symbol reset,
// prefix check (REMOVE_CP_CHECK_EN) and an LCP=1/NFFT=4 instance.
module tb_remove_cp;
    import remove_cp_pkg::*;

`ifdef REMOVE_CP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    remove_cp_if b0();
    remove_cp_if b1();

    remove_cp #(.LCP(16), .NFFT(48), .CP_TOL(1)) u0 (.CLK_I(clk), .RST_I(rst), .bus(b0));
    remove_cp #(.LCP(1),  .NFFT(4),  .CP_TOL(0)) u1 (.CLK_I(clk), .RST_I(rst), .bus(b1));

    int          n_cmp = 0;
    int          n_err = 0;
    int          gcnt  = 0;
    logic [15:0] sv [64];
    logic [15:0] last_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ack, input logic sync, input logic [15:0] v);
        b0.ACK_I = ack; b0.SYNC_I = sync; b0.DAT_I_r = v; b0.DAT_I_i = ~v;
        @(posedge clk); #1;
        b0.ACK_I = 1'b0; b0.SYNC_I = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/stb"},  b0.STB_O, 0);
        chk({tag, "/sof"},  b0.SOF_O, 0);
        chk({tag, "/eof"},  b0.EOF_O, 0);
        chk({tag, "/lock"}, b0.LOCK_O, 0);
        chk({tag, "/serr"}, b0.SYNC_ERR_O, 0);
        chk({tag, "/cerr"}, b0.CP_ERR_O, 0);
        chk({tag, "/cnt"},  b0.SYM_CNT_O, 0);
        chk({tag, "/dr"},   b0.DAT_O_r, 0);
        chk({tag, "/di"},   b0.DAT_O_i, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1 chk_zero(tag);
        @(posedge clk); #1;
        chk_zero(tag);
        rst = 1'b0;
        last_r = 16'h0;
    endtask

    // Sends sv[k0..k1]; sv[0..15] is prefix, sv[16..63] useful samples 0..47.
    task automatic sym(input int k0, input int k1, input bit sync0, input bit gaps,
                       input logic [15:0] base, input bit exp_cp);
        logic [15:0] ni, ecnt;
        for (int k = k0; k <= k1; k++) begin
            if (gaps) begin
                gcnt++;
                if (gcnt % 3 == 0) begin
                    cyc(1'b0, 1'b0, 16'hdead);
                    chk("gap_stb", b0.STB_O, 0);
                    chk("gap_hold", b0.DAT_O_r, last_r);
                end
            end
            cyc(1'b1, sync0 && (k == 0), sv[k]);
            if (k < 16) begin
                chk("pfx_stb", b0.STB_O, 0);
                chk("pfx_hold", b0.DAT_O_r, last_r);
            end else begin
                last_r = sv[k];
                ni = ~sv[k];
                chk("u_stb", b0.STB_O, 1);
                chk("u_dr", b0.DAT_O_r, sv[k]);
                chk("u_di", b0.DAT_O_i, ni);
                chk("u_sof", b0.SOF_O, k == 16);
                chk("u_eof", b0.EOF_O, k == 63);
            end
            ecnt = (k == 63) ? base + 16'd1 : base;
            chk("lock", b0.LOCK_O, 1);
            chk("serr", b0.SYNC_ERR_O, 0);
            chk("symcnt", b0.SYM_CNT_O, ecnt);
            chk("cperr", b0.CP_ERR_O, (k == 63) && exp_cp);
        end
    endtask

    task automatic c1(input logic sync, input logic [15:0] v, input bit estb,
                      input bit esof, input bit eeof, input logic [15:0] ecnt);
        b1.ACK_I = 1'b1; b1.SYNC_I = sync; b1.DAT_I_r = v; b1.DAT_I_i = v;
        @(posedge clk); #1;
        b1.ACK_I = 1'b0; b1.SYNC_I = 1'b0;
        chk("l1_stb", b1.STB_O, estb);
        chk("l1_sof", b1.SOF_O, esof);
        chk("l1_eof", b1.EOF_O, eeof);
        chk("l1_cnt", b1.SYM_CNT_O, ecnt);
        chk("l1_lock", b1.LOCK_O, 1);
        if (estb) chk("l1_dr", b1.DAT_O_r, v);
    endtask

    initial begin
        b0.ACK_I = 0; b0.SYNC_I = 0; b0.DAT_I_r = 0; b0.DAT_I_i = 0;
        b1.ACK_I = 0; b1.SYNC_I = 0; b1.DAT_I_r = 0; b1.DAT_I_i = 0;
        #2 do_reset("rst0");
        chk("l1_rst_lock", b1.LOCK_O, 0);

        // Steady stream 0..63 repeating; prefix 0..15 never matches tail 48..63.
        for (int k = 0; k < 64; k++) sv[k] = 16'(k);
        sym(0, 63, 1, 0, 16'd0, CHK);
        sym(0, 63, 0, 0, 16'd1, CHK);
        sym(0, 63, 0, 0, 16'd2, CHK);
        chk("steady_cnt", b0.SYM_CNT_O, 3);

        // Gaps every third cycle, SYNC on every expected boundary.
        do_reset("rst_gap");
        gcnt = 0;
        sym(0, 63, 1, 1, 16'd0, CHK);
        sym(0, 63, 1, 1, 16'd1, CHK);
        sym(0, 63, 1, 1, 16'd2, CHK);

        // Early SYNC at useful sample 20 of symbol 1.
        do_reset("rst_early");
        sym(0, 63, 1, 0, 16'd0, CHK);
        sym(0, 35, 0, 0, 16'd1, 1'b0);
        cyc(1'b1, 1'b1, sv[0]);
        chk("early_serr", b0.SYNC_ERR_O, 1);
        chk("early_stb", b0.STB_O, 0);
        chk("early_eof", b0.EOF_O, 0);
        chk("early_cnt", b0.SYM_CNT_O, 1);
        chk("early_hold", b0.DAT_O_r, 16'd35);
        sym(1, 63, 0, 0, 16'd1, CHK);

        // Reset at useful sample 30, then a fresh symbol.
        do_reset("rst_mid0");
        sym(0, 46, 1, 0, 16'd0, 1'b0);
        #2 rst = 1'b1;
        #1 chk_zero("mid_async");
        @(posedge clk); #1;
        chk_zero("mid_held");
        rst = 1'b0;
        last_r = 16'h0;
        cyc(1'b1, 1'b0, 16'd5);
        chk("idle_stb", b0.STB_O, 0);
        chk("idle_lock", b0.LOCK_O, 0);
        sym(0, 63, 1, 0, 16'd0, CHK);
        chk("mid_cnt", b0.SYM_CNT_O, 1);

        // Correctly cyclic symbols; useful j = 100+3j, prefix = useful 32..47.
        do_reset("rst_cp");
        for (int j = 0; j < 48; j++) sv[16 + j] = 16'(100 + 3 * j);
        for (int k = 0; k < 16; k++) sv[k] = 16'(100 + 3 * (32 + k));
        sym(0, 63, 1, 0, 16'd0, 1'b0);
        sv[56] = sv[56] + 16'd1;
        sym(0, 63, 0, 0, 16'd1, 1'b0);
        sv[56] = sv[56] + 16'd1;
        sym(0, 63, 0, 0, 16'd2, CHK);
        sv[56] = sv[56] - 16'd2;
        sym(0, 63, 0, 0, 16'd3, 1'b0);

        // LCP=1, NFFT=4: a..e, b..e forwarded; second symbol without SYNC.
        c1(1'b1, 16'd10, 0, 0, 0, 16'd0);
        c1(1'b0, 16'd11, 1, 1, 0, 16'd0);
        c1(1'b0, 16'd12, 1, 0, 0, 16'd0);
        c1(1'b0, 16'd13, 1, 0, 0, 16'd0);
        c1(1'b0, 16'd14, 1, 0, 1, 16'd1);
        c1(1'b0, 16'd20, 0, 0, 0, 16'd1);
        c1(1'b0, 16'd21, 1, 1, 0, 16'd1);
        c1(1'b0, 16'd22, 1, 0, 0, 16'd1);
        c1(1'b0, 16'd23, 1, 0, 0, 16'd1);
        c1(1'b0, 16'd24, 1, 0, 1, 16'd2);
        chk("l1_serr", b1.SYNC_ERR_O, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/remove_cp.md
# remove_cp

Receive-side cyclic-prefix removal stage, directly downstream of the TX prefix inserter across the channel/loopback path. Takes a continuous stream of complex 16-bit samples in which every OFDM symbol is LCP prefix samples followed by NFFT useful samples. Discards the prefix and forwards the NFFT useful samples with frame markers to the receive FFT. Optionally checks that each prefix matches the tail of its symbol.

## Interface
- LCP, 16, prefix length in samples (1..NFFT)
- NFFT, 48, useful samples per symbol (≥2)
- CP_TOL, 0, max allowed |difference| per I/Q component in the prefix check
- CLK_I  in  1  sole clock
- RST_I  in  1  reset; asynchronous, active-high
- DAT_I_r, DAT_I_i  in  16  input sample, two's complement
- ACK_I  in  1  input sample valid this cycle
- SYNC_I  in  1  marks the current sample as prefix sample 0 of a symbol; ignored unless ACK_I=1
- DAT_O_r, DAT_O_i  out  16  useful sample
- STB_O  out  1  output valid
- SOF_O  out  1  with STB_O: useful sample 0
- EOF_O  out  1  with STB_O: useful sample NFFT-1
- LOCK_O  out  1  symbol alignment held
- SYNC_ERR_O  out  1  one-cycle pulse: SYNC_I off the expected boundary
- SYM_CNT_O  out  16  completed symbols, wraps at 65535→0
- CP_ERR_O  out  1  prefix mismatch pulse, coincident with EOF_O

## Operation
- States: IDLE, SKIP, PASS; a counter cnt.
- IDLE: LOCK_O=0; nothing forwarded. ACK_I&SYNC_I → SKIP with cnt=1; that sample is prefix 0.
- SKIP: each ACK_I sample is discarded, cnt+1. The sample with cnt==LCP-1 moves to PASS with cnt=0. With LCP=1, the SYNC sample moves IDLE→PASS directly.
- PASS: each ACK_I sample is forwarded, cnt+1. cnt==0 sets SOF_O. At cnt==NFFT-1: EOF_O is set, SYM_CNT_O increments, and the state goes to SKIP with cnt=0, so back-to-back symbols need no further SYNC_I.
- LOCK_O=1 in SKIP/PASS.
- SYNC_I boundary rule: SYNC_I is expected only in SKIP with cnt==0. SYNC_I with ACK_I anywhere else does all of the following:
  - pulse SYNC_ERR_O
  - abandon the current symbol: no EOF_O, no SYM_CNT_O increment, discard check state
  - restart with that sample as prefix 0
- ACK_I=0 cycles freeze state and cnt; STB_O=0 that cycle.

## Timing
- Output registered: sample accepted at edge n appears on DAT_O_* / STB_O / SOF_O / EOF_O after edge n+1. Latency 1 cycle.
- SYNC_ERR_O asserts 1 cycle after the offending sample, for 1 cycle.
- SYM_CNT_O updates in the same cycle EOF_O is high.
- No backpressure; downstream must accept every STB_O.
- Reset: state IDLE, cnt 0. All outputs 0, including DAT_O_*, SYM_CNT_O and all flags. Check buffer contents don't care.
- Reset mid-symbol aborts immediately; no partial EOF_O follows.
- DAT_O_* holds its last value while STB_O=0.

## Configuration
- REMOVE_CP_CHECK_EN defined:
  - During SKIP, store prefix samples in an LCP-deep buffer.
  - During PASS, compare each sample at cnt = NFFT-LCP+k to buffer[k], k=0..LCP-1.
  - A component mismatch exceeds CP_TOL if |a−b| > CP_TOL, computed in 17 bits.
  - Any such mismatch sets a per-symbol sticky flag. CP_ERR_O=flag, driven with EOF_O. Flag clears at symbol start.
- REMOVE_CP_CHECK_EN undefined:
  - No buffer or comparators.
  - CP_ERR_O tied 0.
  - Port list unchanged.

## Structure
- Shared package: state enum (IDLE/SKIP/PASS), default LCP/NFFT, sample width 16, SYM_CNT width 16.
- One sub-module: remove_cp_check. It holds the prefix buffer, write/read indices, abs-diff compare and sticky flag. It is instantiated only under REMOVE_CP_CHECK_EN.

## Test plan
- Steady stream: reset, then SYNC_I on the first sample, 3×64 samples with values 0..63 repeating, ACK_I=1. Expect:
  - 3 bursts of 48 STB_O with values 16..63
  - SOF_O on value 16, EOF_O on value 63
  - SYM_CNT_O=3, SYNC_ERR_O never
- Gaps: same stream with ACK_I low every third cycle. Expect identical output values and order, with STB_O low in the gap cycles.
- Early SYNC: SYNC_I re-asserted at useful sample 20 of symbol 1. Expect:
  - SYNC_ERR_O pulse; no EOF_O for symbol 1; SYM_CNT_O unchanged
  - next 16 samples discarded, then a full 48-sample burst
- Reset mid-PASS: assert RST_I at useful sample 30, release, send a new SYNC_I plus 64 samples. Expect all outputs 0 during reset, then one clean 48-sample burst and SYM_CNT_O=1.
- Prefix check, with REMOVE_CP_CHECK_EN and CP_TOL=1:
  - correctly cyclic symbol → CP_ERR_O=0
  - tail sample 40 offset by +1 → CP_ERR_O=0
  - tail sample 40 offset by +2 → CP_ERR_O=1 with EOF_O
  - next clean symbol → CP_ERR_O=0
- LCP=1, NFFT=4 build: stream 5-sample symbols a,b,c,d,e. Expect b..e forwarded, SOF_O on b, EOF_O on e.
